pwm_ctrl_multi: RTL and testbench

Parametrised multi-channel LED PWM controller with debounced push-button control, per-channel duty registers, a breathing (auto-ramp) mode and a 6-digit seven-segment readout. It sits directly under the board top level, driving LEDR and HEX0–HEX5 from CLOCK_50 and KEY. It supersedes the single-purpose PWM controller with configurable channel count, resolution, step size and debounce time.

---
 rtl/pwm_ctrl_multi.sv | 210 +++++++++++++++++++++
 tb/tb_pwm_ctrl_multi.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ctrl_multi.sv
// Multi-channel LED PWM controller: debounced keys adjust per-channel duty,
// a shared triangle ramp drives all channels in BREATHE, seven-segment readout.
module pwm_ctrl_multi #(
    parameter int CH   = 10,
    parameter int W    = 8,
    parameter int STEP = 16,
    parameter int DEB  = 500000,
    parameter int PRE  = 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [3:0]    PUSH,
    output logic [CH-1:0] LED,
    output logic [6:0]    HEX0,
    output logic [6:0]    HEX1,
    output logic [6:0]    HEX2,
    output logic [6:0]    HEX3,
    output logic [6:0]    HEX4,
    output logic [6:0]    HEX5
);
    localparam int SW = (CH > 1) ? $clog2(CH) : 1;
    localparam int DW = $clog2(DEB + 1);
    localparam int PW = (PRE > 1) ? $clog2(PRE) : 1;
    localparam logic [W:0]   STEP_V = (W + 1)'(STEP);
    localparam logic [W-1:0] MAXV   = '1;

    typedef enum logic {MANUAL = 1'b0, BREATHE = 1'b1} mode_t;

    function automatic logic [W-1:0] sat_up(input logic [W-1:0] d);
        logic [W:0] s;
        s = {1'b0, d} + STEP_V;
        return (s > {1'b0, MAXV}) ? MAXV : s[W-1:0];
    endfunction

    function automatic logic [W-1:0] sat_dn(input logic [W-1:0] d);
        logic [W:0] s;
        s = {1'b0, d} - STEP_V;
        return s[W] ? '0 : s[W-1:0];
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Value-digit positions wider than W stay blank; the sel digits always show.
    function automatic logic [6:0] hex_rst(input int k);
        return (k >= 4 || 4 * k < W) ? 7'h40 : 7'h7F;
    endfunction

    // Stage p0/p1: synchroniser; stage p2: debounce and press pulse
    logic [3:0]    sync_p0, sync_p1, stable, press_p2;
    logic [DW-1:0] dcnt [4];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_p0  <= '1;
            sync_p1  <= '1;
            stable   <= '1;
            press_p2 <= '0;
            for (int k = 0; k < 4; k++) dcnt[k] <= '0;
        end else begin
            sync_p0 <= PUSH;
            sync_p1 <= sync_p0;
            for (int k = 0; k < 4; k++) begin
                press_p2[k] <= 1'b0;
                if (sync_p1[k] == stable[k]) begin
                    dcnt[k] <= '0;
                end else if (dcnt[k] == DW'(DEB - 1)) begin
                    dcnt[k]     <= '0;
                    stable[k]   <= sync_p1[k];
                    press_p2[k] <= ~sync_p1[k];
                end else begin
                    dcnt[k] <= dcnt[k] + 1'b1;
                end
            end
        end
    end

    mode_t mode, mode_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) mode <= MANUAL;
        else     mode <= mode_nxt;
    end

    always_comb begin
        mode_nxt = mode;
        if (press_p2[3]) mode_nxt = (mode == MANUAL) ? BREATHE : MANUAL;
    end

    logic          key_up, key_dn, enter_br;
    logic [SW-1:0] sel;
    logic [W-1:0]  duty [CH];
    logic [W-1:0]  act  [CH];
    logic [W-1:0]  duty_sel, br, disp;
    logic          br_up;
    logic [PW-1:0] pre_cnt;
    logic [W-1:0]  cnt;
    logic          tick, wrap;

    // Simultaneous UP and DOWN cancel each other.
    assign key_up   = press_p2[0] & ~press_p2[1] & (mode == MANUAL);
    assign key_dn   = press_p2[1] & ~press_p2[0] & (mode == MANUAL);
    assign enter_br = press_p2[3] & (mode == MANUAL);
    assign tick     = (pre_cnt == PW'(PRE - 1));
    assign wrap     = tick && (cnt == MAXV);
    assign disp     = (mode == BREATHE) ? br : duty_sel;

    always_comb begin
        duty_sel = duty[0];
        for (int i = 0; i < CH; i++)
            if (sel == SW'(i)) duty_sel = duty[i];
    end

    // Stage p3: control registers, PWM counter and ramp
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sel     <= '0;
            pre_cnt <= '0;
            cnt     <= '0;
            br      <= '0;
            br_up   <= 1'b1;
            for (int i = 0; i < CH; i++) begin
                duty[i] <= '0;
                act[i]  <= '0;
            end
        end else begin
            if (press_p2[2]) sel <= (sel == SW'(CH - 1)) ? '0 : sel + 1'b1;
            for (int i = 0; i < CH; i++) begin
                if (sel == SW'(i) && key_up) duty[i] <= sat_up(duty[i]);
                if (sel == SW'(i) && key_dn) duty[i] <= sat_dn(duty[i]);
                if (wrap) act[i] <= (mode == BREATHE) ? br : duty[i];
            end
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) cnt <= cnt + 1'b1;
            if (enter_br) begin
                br    <= duty_sel;
                br_up <= 1'b1;
            end else if (mode == BREATHE && wrap) begin
                if (br_up) begin
                    if (br == MAXV) begin
                        br_up <= 1'b0;
                        br    <= br - 1'b1;
                    end else begin
                        br <= br + 1'b1;
                    end
                end else begin
                    if (br == '0) begin
                        br_up <= 1'b1;
                        br    <= br + 1'b1;
                    end else begin
                        br <= br - 1'b1;
                    end
                end
            end
        end
    end

    logic [CH-1:0] led_p4;
    logic [6:0]    hex_p4 [6];
    logic [6:0]    hex_nxt [6];
    logic [15:0]   disp16;
    logic [7:0]    sel8;

    always_comb begin
        disp16 = 16'(disp);
        sel8   = 8'(sel);
        for (int k = 0; k < 4; k++)
            hex_nxt[k] = (4 * k < W) ? seg7(disp16[4 * k +: 4]) : 7'h7F;
        hex_nxt[4] = seg7(sel8[3:0]);
        hex_nxt[5] = seg7(sel8[7:4]);
    end

    // Stage p4: registered LED compare and segment decode
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            led_p4 <= '0;
            for (int k = 0; k < 6; k++) hex_p4[k] <= hex_rst(k);
        end else begin
            for (int i = 0; i < CH; i++) led_p4[i] <= (cnt < act[i]);
            for (int k = 0; k < 6; k++) hex_p4[k] <= hex_nxt[k];
        end
    end

    assign LED  = led_p4;
    assign HEX0 = hex_p4[0];
    assign HEX1 = hex_p4[1];
    assign HEX2 = hex_p4[2];
    assign HEX3 = hex_p4[3];
    assign HEX4 = hex_p4[4];
    assign HEX5 = hex_p4[5];

endmodule

// File: tb/tb_pwm_ctrl_multi.sv
// Bench for pwm_ctrl_multi: behavioural model compared every cycle, plus
// directed key sequences with hand-computed readouts and LED duty counts.
module tb_pwm_ctrl_multi;
    localparam int CH = 4, W = 4, STEP = 4, DEB = 4, PRE = 1;
    localparam int MAXV = (1 << W) - 1;
    localparam int PER  = 1 << W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    push = 4'hF;
    logic [CH-1:0] led;
    logic [6:0]    hex0, hex1, hex2, hex3, hex4, hex5;

    int n_checks = 0;
    int n_errors = 0;

    pwm_ctrl_multi #(.CH(CH), .W(W), .STEP(STEP), .DEB(DEB), .PRE(PRE)) dut (
        .CLK(clk), .RST(rst), .PUSH(push), .LED(led),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
            12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    // Triangle wave position -> ramp value: climbs to MAXV then descends.
    function automatic int tri_wave(input int pos);
        int p;
        p = pos % (2 * MAXV);
        return (p <= MAXV) ? p : 2 * MAXV - p;
    endfunction

    // Model state, advanced once per rising edge.
    logic [3:0]    m_d1, m_d2, m_stable, m_press;
    int            m_run [4];
    int            m_duty [CH];
    int            m_act [CH];
    int            m_sel, m_brpos, m_ncyc;
    bit            m_breathe;
    logic [CH-1:0] m_led;
    logic [6:0]    m_hex [6];

    task automatic model_reset();
        m_d1 = 4'hF; m_d2 = 4'hF; m_stable = 4'hF; m_press = 4'h0;
        for (int k = 0; k < 4; k++) m_run[k] = 0;
        for (int i = 0; i < CH; i++) begin
            m_duty[i] = 0;
            m_act[i]  = 0;
        end
        m_sel = 0; m_brpos = 0; m_ncyc = 0; m_breathe = 1'b0;
        m_led = '0;
        for (int k = 0; k < 4; k++) m_hex[k] = (4 * k < W) ? 7'h40 : 7'h7F;
        m_hex[4] = 7'h40;
        m_hex[5] = 7'h40;
    endtask

    task automatic model_step();
        int cnt_now, disp;
        bit wrap, kup, kdn;
        logic [3:0] np;
        cnt_now = (m_ncyc / PRE) % PER;
        wrap    = (m_ncyc % (PRE * PER)) == PRE * PER - 1;
        for (int i = 0; i < CH; i++) m_led[i] = (cnt_now < m_act[i]);
        disp = m_breathe ? tri_wave(m_brpos) : m_duty[m_sel];
        for (int k = 0; k < 4; k++) m_hex[k] = (4 * k < W) ? glyph((disp >> (4 * k)) & 15) : 7'h7F;
        m_hex[4] = glyph(m_sel % 16);
        m_hex[5] = glyph(m_sel / 16);
        if (wrap)
            for (int i = 0; i < CH; i++) m_act[i] = m_breathe ? tri_wave(m_brpos) : m_duty[i];
        kup = m_press[0] && !m_press[1] && !m_breathe;
        kdn = m_press[1] && !m_press[0] && !m_breathe;
        if (m_press[3] && !m_breathe) m_brpos = m_duty[m_sel];
        else if (m_breathe && wrap)   m_brpos++;
        if (kup) m_duty[m_sel] = (m_duty[m_sel] + STEP > MAXV) ? MAXV : m_duty[m_sel] + STEP;
        if (kdn) m_duty[m_sel] = (m_duty[m_sel] < STEP) ? 0 : m_duty[m_sel] - STEP;
        if (m_press[2]) m_sel = (m_sel + 1) % CH;
        if (m_press[3]) m_breathe = !m_breathe;
        np = 4'h0;
        for (int k = 0; k < 4; k++) begin
            if (m_d2[k] != m_stable[k]) begin
                m_run[k]++;
                if (m_run[k] == DEB) begin
                    m_stable[k] = m_d2[k];
                    m_run[k]    = 0;
                    np[k]       = !m_d2[k];
                end
            end else begin
                m_run[k] = 0;
            end
        end
        m_press = np;
        m_d2 = m_d1;
        m_d1 = push;
        m_ncyc++;
    endtask

    always @(posedge clk) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("led", int'(led), int'(m_led));
            check("hex0", int'(hex0), int'(m_hex[0]));
            check("hex1", int'(hex1), int'(m_hex[1]));
            check("hex2", int'(hex2), int'(m_hex[2]));
            check("hex3", int'(hex3), int'(m_hex[3]));
            check("hex4", int'(hex4), int'(m_hex[4]));
            check("hex5", int'(hex5), int'(m_hex[5]));
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int k);
        push[k] = 1'b0;
        wait_cycles(10);
        push[k] = 1'b1;
        wait_cycles(12);
    endtask

    task automatic count_high(input int ch, output int n);
        n = 0;
        repeat (PER) begin
            @(negedge clk);
            n += int'(led[ch]);
        end
    endtask

    task automatic check_reset_view(input string tag);
        check({tag, "_led"}, int'(led), 0);
        check({tag, "_hex0"}, int'(hex0), 7'h40);
        check({tag, "_hex1"}, int'(hex1), 7'h7F);
        check({tag, "_hex2"}, int'(hex2), 7'h7F);
        check({tag, "_hex3"}, int'(hex3), 7'h7F);
        check({tag, "_hex4"}, int'(hex4), 7'h40);
        check({tag, "_hex5"}, int'(hex5), 7'h40);
    endtask

    initial begin
        int n;
        int peak;
        wait_cycles(3);
        check_reset_view("rst0");
        rst = 1'b0;
        wait_cycles(5);

        // Duty ramp with saturation on channel 0
        press(0); check("up1", int'(hex0), 7'h19);
        press(0); check("up2", int'(hex0), 7'h00);
        press(0); check("up3", int'(hex0), 7'h46);
        wait_cycles(2 * PER);
        count_high(0, n); check("led0_duty12", n, 12);
        press(0); check("up4_sat", int'(hex0), 7'h0E);
        press(0); check("up5_sat", int'(hex0), 7'h0E);

        // Floor, and UP+DOWN together
        press(1); check("dn1", int'(hex0), 7'h03);
        push = 4'b1100;
        wait_cycles(10);
        push = 4'b1111;
        wait_cycles(12);
        check("updn_same", int'(hex0), 7'h03);
        press(1); check("dn2", int'(hex0), 7'h78);
        press(1); check("dn3", int'(hex0), 7'h30);
        press(1); check("dn4", int'(hex0), 7'h40);
        press(1); check("dn5_floor", int'(hex0), 7'h40);
        wait_cycles(2 * PER);
        count_high(0, n); check("led0_duty0", n, 0);

        // Channel select with UP applied at sel=2
        press(2); check("sel1", int'(hex4), 7'h79);
        press(2); check("sel2", int'(hex4), 7'h24);
        press(0); check("sel2_up", int'(hex0), 7'h19);
        press(2); check("sel3", int'(hex4), 7'h30);
        press(2); check("sel0", int'(hex4), 7'h40);
        wait_cycles(2 * PER);
        count_high(2, n); check("led2_duty4", n, 4);
        count_high(0, n); check("led0_still0", n, 0);

        // Debounce: short glitch, minimum press, bouncing press
        push[0] = 1'b0; wait_cycles(3); push[0] = 1'b1; wait_cycles(15);
        check("glitch3", int'(hex0), 7'h40);
        push[0] = 1'b0; wait_cycles(6); push[0] = 1'b1; wait_cycles(15);
        check("pulse6", int'(hex0), 7'h19);
        push[0] = 1'b0; wait_cycles(2); push[0] = 1'b1; wait_cycles(2);
        push[0] = 1'b0; wait_cycles(1); push[0] = 1'b1; wait_cycles(1);
        push[0] = 1'b0; wait_cycles(12); push[0] = 1'b1; wait_cycles(15);
        check("bounce", int'(hex0), 7'h00);

        // Breathe on sel=1 (duty 0) so the ramp starts from 0
        press(2); check("sel1_b", int'(hex4), 7'h79);
        press(3);
        peak = 0;
        repeat (35 * PER) begin
            @(negedge clk);
            if (hex0 == 7'h0E) peak++;
        end
        check("br_peak_cycles", peak, PER);
        press(0);
        press(3);
        wait_cycles(2 * PER);
        check("manual_hex0", int'(hex0), 7'h40);
        count_high(0, n); check("led0_restored", n, 8);
        count_high(2, n); check("led2_restored", n, 4);
        count_high(1, n); check("led1_restored", n, 0);

        // Asynchronous reset mid-press; held key re-fires after release
        push[0] = 1'b0;
        wait_cycles(3);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_reset_view("rst_mid");
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(20);
        check("held_after_rst", int'(hex0), 7'h19);
        push[0] = 1'b1;
        wait_cycles(20);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
